mem_responder: RTL and testbench

- Memory-side responder for the CPU's MDR/MAR datapath: services Read/Write strobes using the MAR address and MDR contents.
- Returns read data on Mdatain, which feeds the MDR's memory input, after a configurable number of wait states, then signals completion with a one-cycle mem_ready pulse.
- Holds the word-addressed RAM array.
- Enforces one transaction per strobe assertion.

---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the MDR/MAR datapath.
// Serves one Read/Write strobe per assertion, with a configurable number of wait states.
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  error
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam int         DEPTH     = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_wr_q, op_wr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic                  mem_we_s;

  // Next-state logic for the IDLE/WAIT/HOLD transaction sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_wr_d  = op_wr_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    error_d  = 1'b0;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Read ^ Write) begin
          addr_d  = address;
          data_d  = data_in;
          op_wr_d = Write;
          cnt_d   = WAIT_INIT;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end else if (Read && Write) begin
          error_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_HOLD;
          if (op_wr_q) begin
            mem_we_s = 1'b1;
          end else begin
            rdata_d = mem_q[addr_q];
          end
        end
      end
      ST_HOLD: begin
        // One transaction per strobe: wait for both strobes to drop.
        if (!Read && !Write) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers; clear has priority.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  // RAM array is not reset; a clear on the commit edge aborts the write.
  always_ff @(posedge clock) begin
    if (mem_we_s && !clear) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign Mdatain   = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [8:0]  addr0 = 9'd0, addr1 = 9'd0;
  logic [31:0] din0 = 32'd0, din1 = 32'd0;
  logic [31:0] mdat0, mdat1;
  logic        rdy0, busy0, err0, rdy1, busy1, err1;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut0 (
    .clock(clock), .clear(clear), .Read(rd0), .Write(wr0), .address(addr0), .data_in(din0),
    .Mdatain(mdat0), .mem_ready(rdy0), .busy(busy0), .error(err0)
  );

  mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut1 (
    .clock(clock), .clear(clear), .Read(rd1), .Write(wr1), .address(addr1), .data_in(din1),
    .Mdatain(mdat1), .mem_ready(rdy1), .busy(busy1), .error(err1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on dut0: strobe until mem_ready, check latency, drop strobes.
  task automatic txn0(input logic rd, input logic wr, input logic [8:0] a,
                      input logic [31:0] d, input string tag);
    int n;
    bit seen;
    rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (rdy0) seen = 1'b1;
    end
    check_eq({tag, "_lat"}, n, 32'd4);
    rd0 = 1'b0; wr0 = 1'b0;
    @(negedge clock);
    check_eq({tag, "_rdy_drop"}, {31'd0, rdy0}, 32'd0);
  endtask

  initial begin
    int pulses;
    // Reset
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    check_eq("rst_mdat", mdat0, 32'h0000_0000);
    check_eq("rst_flags", {29'd0, rdy0, busy0, err0}, 32'd0);

    // Write DEADBEEF to 0x005; changing inputs during WAIT must be ignored
    wr0 = 1'b1; addr0 = 9'h005; din0 = 32'hDEAD_BEEF;
    @(negedge clock);
    check_eq("wr_e0_busy", {30'd0, rdy0, busy0}, 32'd1);
    addr0 = 9'h0AA; din0 = 32'h1111_1111;
    @(negedge clock);
    check_eq("wr_e1", {30'd0, rdy0, busy0}, 32'd1);
    @(negedge clock);
    check_eq("wr_e2", {30'd0, rdy0, busy0}, 32'd1);
    @(negedge clock);
    check_eq("wr_e3", {30'd0, rdy0, busy0}, 32'd2);
    check_eq("wr_mdat", mdat0, 32'h0000_0000);
    wr0 = 1'b0;
    @(negedge clock);
    check_eq("wr_e4_rdy", {31'd0, rdy0}, 32'd0);

    // Read back, then keep Read high for 12 cycles: exactly one pulse
    txn0(1'b1, 1'b0, 9'h005, 32'd0, "rd5");
    check_eq("rd5_data", mdat0, 32'hDEAD_BEEF);
    rd0 = 1'b1; addr0 = 9'h005;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (rdy0) pulses++;
    end
    check_eq("hold_pulses", pulses, 32'd1);
    check_eq("hold_busy", {31'd0, busy0}, 32'd0);
    check_eq("hold_mdat", mdat0, 32'hDEAD_BEEF);
    rd0 = 1'b0;
    @(negedge clock);

    // Simultaneous Read and Write: error pulse, no access
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 9'h005; din0 = 32'h0000_0000;
    @(negedge clock);
    check_eq("err_pulse", {29'd0, rdy0, busy0, err0}, 32'd1);
    @(negedge clock);
    check_eq("err_drop", {29'd0, rdy0, busy0, err0}, 32'd0);
    rd0 = 1'b0; wr0 = 1'b0;
    @(negedge clock);
    txn0(1'b1, 1'b0, 9'h005, 32'd0, "rd_after_err");
    check_eq("rd_after_err_data", mdat0, 32'hDEAD_BEEF);

    // Clear during WAIT aborts a write to 0x010
    txn0(1'b0, 1'b1, 9'h010, 32'h0BAD_CAFE, "wr10");
    wr0 = 1'b1; addr0 = 9'h010; din0 = 32'h1234_5678;
    @(negedge clock);
    check_eq("abort_busy", {31'd0, busy0}, 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0; wr0 = 1'b0;
    check_eq("abort_mdat", mdat0, 32'h0000_0000);
    check_eq("abort_flags", {29'd0, rdy0, busy0, err0}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rdy0) pulses++;
    end
    check_eq("abort_no_rdy", pulses, 32'd0);
    txn0(1'b1, 1'b0, 9'h010, 32'd0, "rd10");
    check_eq("rd10_data", mdat0, 32'h0BAD_CAFE);

    // WAIT_STATES=0 instance
    wr1 = 1'b1; addr1 = 9'h1FF; din1 = 32'hCAFE_F00D;
    @(negedge clock);
    check_eq("ws0_wr_e0", {30'd0, rdy1, busy1}, 32'd1);
    @(negedge clock);
    check_eq("ws0_wr_e1", {30'd0, rdy1, busy1}, 32'd2);
    check_eq("ws0_wr_mdat", mdat1, 32'h0000_0000);
    wr1 = 1'b0;
    @(negedge clock);
    rd1 = 1'b1;
    @(negedge clock);
    check_eq("ws0_rd_e0", {30'd0, rdy1, busy1}, 32'd1);
    @(negedge clock);
    check_eq("ws0_rd_e1", {30'd0, rdy1, busy1}, 32'd2);
    check_eq("ws0_rd_data", mdat1, 32'hCAFE_F00D);
    rd1 = 1'b0;
    @(negedge clock);
    check_eq("ws0_rd_drop", {31'd0, rdy1}, 32'd0);
    check_eq("ws0_mdat_hold", mdat1, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
